// File: rtl/mmio_bus_controller.sv
// CPU-side MMIO decoder: base/mask region select, ready handshake, slave timeout.
// Optional error capture registers are enabled with `define BUS_ERR_CAPTURE_EN.
module mmio_bus_controller #(
   parameter int dataWidth    = 8,
   parameter int addressWidth = 32,
   parameter int N_SLAVES     = 4,
   parameter logic [N_SLAVES*addressWidth-1:0] SLV_BASE =
      {32'h1000_0000, 32'h0100_0000, 32'h0010_0000, 32'h0000_0000},
   parameter logic [N_SLAVES*addressWidth-1:0] SLV_MASK =
      {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_F000, 32'hFFFF_F000},
   parameter int TIMEOUT      = 15
) (
   input  logic                         clk,
   input  logic                         rst,
`ifdef BUS_ERR_CAPTURE_EN
   input  logic                         err_clear,
   output logic                         err_valid,
   output logic [addressWidth-1:0]      err_addr,
   output logic [1:0]                   err_cause,
`endif
   input  logic                         readmem,
   input  logic                         writemem,
   input  logic [addressWidth-1:0]      addressBus,
   input  logic [dataWidth-1:0]         dataBusIn,
   output logic [dataWidth-1:0]         dataBusOut,
   output logic                         memDataReady,
   output logic                         busError,
   output logic [N_SLAVES-1:0]          slv_sel,
   output logic                         slv_read,
   output logic                         slv_write,
   output logic [addressWidth-1:0]      slv_addr,
   output logic [dataWidth-1:0]         slv_wdata,
   input  logic [N_SLAVES*dataWidth-1:0] slv_rdata,
   input  logic [N_SLAVES-1:0]          slv_ready
);

   localparam int IW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

   state_t                  state_q, state_d;
   logic [7:0]              cnt_q, cnt_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic                    wr_q, wr_d;
   logic [addressWidth-1:0] off_q, off_d;
   logic [dataWidth-1:0]    wd_q, wd_d;
   logic [dataWidth-1:0]    dbo_q, dbo_d;
   logic [addressWidth-1:0] addr_q, addr_d;
   logic [1:0]              cause_q, cause_d;

   logic                    hit;
   logic [IW-1:0]           hit_idx;
   logic [addressWidth-1:0] hit_off;

   // Scan from the top so the lowest matching index is the one left standing.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      hit_off = '0;
      for (int i = N_SLAVES - 1; i >= 0; i--) begin
         if ((addressBus & SLV_MASK[i*addressWidth +: addressWidth]) ==
             SLV_BASE[i*addressWidth +: addressWidth]) begin
            hit     = 1'b1;
            hit_idx = IW'(i);
            hit_off = addressBus & ~SLV_MASK[i*addressWidth +: addressWidth];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wr_d    = wr_q;
      off_d   = off_q;
      wd_d    = wd_q;
      dbo_d   = dbo_q;
      addr_d  = addr_q;
      cause_d = cause_q;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (readmem | writemem) begin
               idx_d  = hit_idx;
               wr_d   = writemem;
               off_d  = hit_off;
               wd_d   = dataBusIn;
               addr_d = addressBus;
               if (readmem & writemem) begin
                  state_d = ERR;
                  cause_d = 2'b11;
               end else if (!hit) begin
                  state_d = ERR;
                  cause_d = 2'b01;
               end else begin
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: begin
            if (slv_ready[idx_q]) begin
               if (!wr_q) dbo_d = slv_rdata[idx_q*dataWidth +: dataWidth];
               state_d = DONE;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ERR;
               cause_d = 2'b10;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         DONE:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wr_q    <= 1'b0;
         off_q   <= '0;
         wd_q    <= '0;
         dbo_q   <= '0;
         addr_q  <= '0;
         cause_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wr_q    <= wr_d;
         off_q   <= off_d;
         wd_q    <= wd_d;
         dbo_q   <= dbo_d;
         addr_q  <= addr_d;
         cause_q <= cause_d;
      end
   end

   always_comb begin
      slv_sel = '0;
      if (state_q == ACCESS) slv_sel[idx_q] = 1'b1;
   end

   assign slv_read     = (state_q == ACCESS) & ~wr_q;
   assign slv_write    = (state_q == ACCESS) & wr_q;
   assign slv_addr     = off_q;
   assign slv_wdata    = wd_q;
   assign dataBusOut   = dbo_q;
   assign memDataReady = (state_q == DONE) | (state_q == ERR);
   assign busError     = (state_q == ERR);

`ifdef BUS_ERR_CAPTURE_EN
   logic                    ev_q, ev_d;
   logic [addressWidth-1:0] ea_q, ea_d;
   logic [1:0]              ec_q, ec_d;

   // A clear and a new error in the same cycle: the new error wins.
   always_comb begin
      ev_d = ev_q;
      ea_d = ea_q;
      ec_d = ec_q;
      if ((state_q == ERR) && (!ev_q || err_clear)) begin
         ev_d = 1'b1;
         ea_d = addr_q;
         ec_d = cause_q;
      end else if (err_clear) begin
         ev_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ev_q <= 1'b0;
         ea_q <= '0;
         ec_q <= '0;
      end else begin
         ev_q <= ev_d;
         ea_q <= ea_d;
         ec_q <= ec_d;
      end
   end

   assign err_valid = ev_q;
   assign err_addr  = ea_q;
   assign err_cause = ec_q;
`endif

endmodule
